// File: rtl/mat_stream_loader.sv
// Assembles a row-major element stream into a NUM_ROWS x NUM_COLS matrix and holds
// it on mat_out until the downstream transpose stage accepts it via mat_valid/mat_ready.
module mat_stream_loader #(
  parameter int NUM_ROWS   = 1,
  parameter int NUM_COLS   = 1,
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PNT  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic signed [DATA_WIDTH-1:0] mat_out [NUM_ROWS][NUM_COLS],
  output logic                         mat_valid,
  input  logic                         mat_ready,
  output logic                         err_frame
);

  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(NUM_COLS - 1);

  // FIXED_PNT only describes the format seen by later stages; reject nonsense here.
  if (NUM_ROWS < 1 || NUM_COLS < 1 || FIXED_PNT < 0 || FIXED_PNT > DATA_WIDTH) begin : g_bad_param
    $error("mat_stream_loader: illegal parameter combination");
  end

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic [RW-1:0]                  row_q, row_d;
  logic [CW-1:0]                  col_q, col_d;
  logic                           err_frame_q, err_frame_d;
  logic signed [DATA_WIDTH-1:0]   mat_q [NUM_ROWS][NUM_COLS];
  logic signed [DATA_WIDTH-1:0]   mat_d [NUM_ROWS][NUM_COLS];
  logic                           is_final;

  assign is_final = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    err_frame_d = 1'b0;
    mat_d       = mat_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          mat_d[row_q][col_q] = in_data;
          if (is_final) begin
            state_d     = HOLD;
            row_d       = '0;
            col_d       = '0;
            err_frame_d = !in_last;
          end else if (in_last) begin
            // Early in_last: abandon the partial frame, written elements stay but never go valid.
            row_d       = '0;
            col_d       = '0;
            err_frame_d = 1'b1;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (mat_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      row_q       <= '0;
      col_q       <= '0;
      err_frame_q <= 1'b0;
      mat_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      err_frame_q <= err_frame_d;
      mat_q       <= mat_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign mat_valid = (state_q == HOLD);
  assign err_frame = err_frame_q;
  assign mat_out   = mat_q;

endmodule
